// File: rtl/sram_1w1r_mbist_if.sv
// Bundle of functional W0/R0 ports, macro pins and BIST control/status for the 1w1r MBIST mux.
// Slave side is the controller; master side drives functional inputs, the macro read data and bist_start.
interface sram_1w1r_mbist_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 44,
  parameter int MASK_W = 4
);
  logic [ADDR_W-1:0] W0_addr;
  logic [DATA_W-1:0] W0_data;
  logic              W0_en;
  logic [MASK_W-1:0] W0_mask;
  logic [ADDR_W-1:0] R0_addr;
  logic              R0_en;
  logic [DATA_W-1:0] R0_data;

  logic              mem_csb0;
  logic [ADDR_W-1:0] mem_addr0;
  logic [DATA_W-1:0] mem_din0;
  logic [MASK_W-1:0] mem_wmask0;
  logic              mem_csb1;
  logic [ADDR_W-1:0] mem_addr1;
  logic [DATA_W-1:0] mem_dout1;

  logic              bist_start;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_fail;
  logic [ADDR_W-1:0] bist_fail_addr;

  modport slave (
    input  W0_addr, W0_data, W0_en, W0_mask, R0_addr, R0_en, mem_dout1, bist_start,
    output R0_data, mem_csb0, mem_addr0, mem_din0, mem_wmask0, mem_csb1, mem_addr1,
           bist_busy, bist_done, bist_fail, bist_fail_addr
  );

  modport master (
    output W0_addr, W0_data, W0_en, W0_mask, R0_addr, R0_en, mem_dout1, bist_start,
    input  R0_data, mem_csb0, mem_addr0, mem_din0, mem_wmask0, mem_csb1, mem_addr1,
           bist_busy, bist_done, bist_fail, bist_fail_addr
  );
endinterface

// File: rtl/sram_1w1r_mbist.sv
// March C- self-test controller and port mux in front of a 1w1r SRAM macro; functional ports pass through combinationally.
// A test occupies the macro for 10*DEPTH+1 cycles; functional accesses issued meanwhile are dropped, not stalled.
module sram_1w1r_mbist #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 44,
  parameter int MASK_W = 4,
  parameter int DEPTH  = 128
) (
  input  logic clock,
  input  logic reset_n,
  sram_1w1r_mbist_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic [2:0]        elem;
  logic [ADDR_W-1:0] addr;
  logic              phase;
  logic              cmp_vld;
  logic              cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;

  logic two_op, is_down, next_down, rd_op, wr_op, rd_pat, wr_pat, last_op, at_end, bist_mode;

  // E1..E4 alternate read/write per address; E0 only writes and E5 only reads.
  always_comb begin
    two_op    = (elem >= 3'd1) && (elem <= 3'd4);
    is_down   = (elem == 3'd3) || (elem == 3'd4);
    next_down = (elem == 3'd2) || (elem == 3'd3);
    rd_pat    = (elem == 3'd2) || (elem == 3'd4);
    wr_pat    = (elem == 3'd1) || (elem == 3'd3);
    rd_op     = (state == MARCH) && ((elem == 3'd5) || (two_op && !phase));
    wr_op     = (state == MARCH) && ((elem == 3'd0) || (two_op && phase));
    last_op   = !two_op || phase;
    at_end    = is_down ? (addr == '0) : (addr == LAST);
    bist_mode = (state == MARCH) || (state == DRAIN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      elem      <= '0;
      addr      <= '0;
      phase     <= 1'b0;
      cmp_vld   <= 1'b0;
      cmp_exp   <= 1'b0;
      cmp_addr  <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
    end else begin
      cmp_vld  <= rd_op;
      cmp_exp  <= rd_pat;
      cmp_addr <= addr;
      if (cmp_vld && (bus.mem_dout1 != {DATA_W{cmp_exp}})) begin
        fail <= 1'b1;
        if (!fail) fail_addr <= cmp_addr;
      end
      case (state)
        IDLE, DONE: begin
          if (bus.bist_start) begin
            state     <= MARCH;
            elem      <= '0;
            addr      <= '0;
            phase     <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
          end
        end
        MARCH: begin
          if (two_op) phase <= ~phase;
          if (last_op) begin
            if (at_end) begin
              if (elem == 3'd5) begin
                state <= DRAIN;
              end else begin
                elem <= elem + 3'd1;
                addr <= next_down ? LAST : '0;
              end
            end else begin
              addr <= is_down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
            end
          end
        end
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_csb0   = bist_mode ? ~wr_op : ~bus.W0_en;
    bus.mem_addr0  = bist_mode ? addr : bus.W0_addr;
    bus.mem_din0   = bist_mode ? {DATA_W{wr_pat}} : bus.W0_data;
    bus.mem_wmask0 = bist_mode ? {MASK_W{1'b1}} : bus.W0_mask;
    bus.mem_csb1   = bist_mode ? ~rd_op : ~bus.R0_en;
    bus.mem_addr1  = bist_mode ? addr : bus.R0_addr;
    bus.R0_data        = bus.mem_dout1;
    bus.bist_busy      = bist_mode;
    bus.bist_done      = (state == DONE);
    bus.bist_fail      = fail;
    bus.bist_fail_addr = fail_addr;
  end

endmodule

// File: tb/tb_sram_1w1r_mbist.sv
// Bench for sram_1w1r_mbist: two instances (DEPTH 16 and 48) each driving a behavioural 1w1r macro with fault injection.
// Expected test outcomes are queued at start and compared when bist_done appears; every BIST cycle is checked against an arithmetic March C- schedule.
module tb_sram_1w1r_mbist;
  localparam int DW = 44;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sram_1w1r_mbist_if #(.ADDR_W(7), .DATA_W(DW), .MASK_W(4)) ba();
  sram_1w1r_mbist_if #(.ADDR_W(6), .DATA_W(DW), .MASK_W(4)) bb();

  sram_1w1r_mbist #(.ADDR_W(7), .DATA_W(DW), .MASK_W(4), .DEPTH(16)) dut_a (
    .clock(clk), .reset_n(rst_n), .bus(ba));
  sram_1w1r_mbist #(.ADDR_W(6), .DATA_W(DW), .MASK_W(4), .DEPTH(48)) dut_b (
    .clock(clk), .reset_n(rst_n), .bus(bb));

  logic [DW-1:0] mem_a [128];
  logic [DW-1:0] s1_a  [128];
  logic [DW-1:0] s0_a  [128];
  logic [DW-1:0] mem_b [64];

  function automatic logic [DW-1:0] bitmask(input logic [3:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = m[i / 11];
    return r;
  endfunction

  // Macro models: write and registered read on the clock edge, stuck-at faults applied on read.
  always @(posedge clk) begin
    if (!ba.mem_csb0)
      mem_a[ba.mem_addr0] <= (mem_a[ba.mem_addr0] & ~bitmask(ba.mem_wmask0)) |
                             (ba.mem_din0 & bitmask(ba.mem_wmask0));
    if (!ba.mem_csb1)
      ba.mem_dout1 <= (mem_a[ba.mem_addr1] | s1_a[ba.mem_addr1]) & ~s0_a[ba.mem_addr1];
  end

  always @(posedge clk) begin
    if (!bb.mem_csb0)
      mem_b[bb.mem_addr0] <= (mem_b[bb.mem_addr0] & ~bitmask(bb.mem_wmask0)) |
                             (bb.mem_din0 & bitmask(bb.mem_wmask0));
    if (!bb.mem_csb1)
      bb.mem_dout1 <= mem_b[bb.mem_addr1];
  end

  typedef struct {
    int busy;
    bit fail;
    int faddr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] rd_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic get_sig(input int inst, output logic busy, output logic done, output logic fail,
                         output int faddr, output logic csb0, output logic csb1, output int a0,
                         output int a1, output logic [DW-1:0] din, output logic [3:0] wm);
    if (inst == 0) begin
      busy = ba.bist_busy; done = ba.bist_done; fail = ba.bist_fail; faddr = int'(ba.bist_fail_addr);
      csb0 = ba.mem_csb0; csb1 = ba.mem_csb1; a0 = int'(ba.mem_addr0); a1 = int'(ba.mem_addr1);
      din = ba.mem_din0; wm = ba.mem_wmask0;
    end else begin
      busy = bb.bist_busy; done = bb.bist_done; fail = bb.bist_fail; faddr = int'(bb.bist_fail_addr);
      csb0 = bb.mem_csb0; csb1 = bb.mem_csb1; a0 = int'(bb.mem_addr0); a1 = int'(bb.mem_addr1);
      din = bb.mem_din0; wm = bb.mem_wmask0;
    end
  endtask

  // Expected macro operation in busy cycle k of a March C- run over d words.
  task automatic exp_op(input int d, input int k, output bit w, output bit r, output int a, output bit p);
    int j, e, i;
    w = 0; r = 0; a = 0; p = 0;
    if (k < d) begin
      w = 1; a = k;
    end else if (k < 9 * d) begin
      j = k - d;
      e = j / (2 * d) + 1;
      i = (j % (2 * d)) / 2;
      a = (e == 3 || e == 4) ? d - 1 - i : i;
      if (j % 2 == 1) begin
        w = 1; p = (e == 1 || e == 3);
      end else begin
        r = 1;
      end
    end else if (k < 10 * d) begin
      r = 1; a = k - 9 * d;
    end
  endtask

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) ba.bist_start = v;
    else           bb.bist_start = v;
  endtask

  task automatic run_bist(input int inst, input bit hold, input bit spam, input bit exp_fail,
                          input int exp_faddr, input string tag);
    int d, k, proto, oob, a0, a1, a, faddr;
    logic busy, done, fail, csb0, csb1;
    logic [DW-1:0] din;
    logic [3:0] wm;
    bit w, r, p;
    exp_t e;
    d = (inst == 0) ? 16 : 48;
    e.busy = 10 * d + 1; e.fail = exp_fail; e.faddr = exp_faddr;
    exp_q.push_back(e);
    @(negedge clk);
    set_start(inst, 1'b1);
    if (spam) begin
      ba.W0_en = 1'b1; ba.W0_addr = 7'd0; ba.W0_data = '1; ba.W0_mask = 4'hF;
    end
    @(negedge clk);
    if (!hold) set_start(inst, 1'b0);
    k = 0; proto = 0; oob = 0;
    for (int c = 0; c < 12 * d + 20; c++) begin
      get_sig(inst, busy, done, fail, faddr, csb0, csb1, a0, a1, din, wm);
      if (busy === 1'b1) begin
        exp_op(d, k, w, r, a, p);
        if (csb0 !== !w) proto++;
        if (csb1 !== !r) proto++;
        if (w && (a0 != a || din !== {DW{p}} || wm !== 4'hF)) proto++;
        if (r && a1 != a) proto++;
        if ((csb0 === 1'b0 && a0 >= d) || (csb1 === 1'b0 && a1 >= d)) oob++;
        if (k == 0) chk({tag, "_fail_clr"}, fail, 1'b0);
        if (k == 5 * d) chk({tag, "_e3_start"}, a1, d - 1);
        k++;
      end else if (done === 1'b1) begin
        break;
      end
      @(negedge clk);
    end
    set_start(inst, 1'b0);
    ba.W0_en = 1'b0;
    get_sig(inst, busy, done, fail, faddr, csb0, csb1, a0, a1, din, wm);
    e = exp_q.pop_front();
    chk({tag, "_busy_cycles"}, k, e.busy);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_fail"}, fail, e.fail);
    chk({tag, "_fail_addr"}, faddr, e.faddr);
    chk({tag, "_schedule"}, proto, 0);
    chk({tag, "_oob"}, oob, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem_a[i] = '0; s1_a[i] = '0; s0_a[i] = '0;
    end
    for (int i = 0; i < 64; i++) mem_b[i] = '0;
    ba.W0_addr = '0; ba.W0_data = '0; ba.W0_en = 1'b0; ba.W0_mask = '0;
    ba.R0_addr = '0; ba.R0_en = 1'b0; ba.bist_start = 1'b0;
    bb.W0_addr = '0; bb.W0_data = '0; bb.W0_en = 1'b0; bb.W0_mask = '0;
    bb.R0_addr = '0; bb.R0_en = 1'b0; bb.bist_start = 1'b0;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", ba.bist_busy, 1'b0);
    chk("rst_done", ba.bist_done, 1'b0);
    chk("rst_fail", ba.bist_fail, 1'b0);
    chk("rst_fail_addr", ba.bist_fail_addr, 7'd0);
    chk("rst_csb0", ba.mem_csb0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Functional mux, set and withdrawn before the next edge so no write lands.
    ba.W0_en = 1'b1; ba.W0_addr = 7'd7; ba.W0_mask = 4'h6; ba.W0_data = 44'h123;
    #1;
    chk("func_csb0", ba.mem_csb0, 1'b0);
    chk("func_addr0", ba.mem_addr0, 7'd7);
    chk("func_wmask", ba.mem_wmask0, 4'h6);
    chk("func_din", ba.mem_din0, 44'h123);
    ba.W0_en = 1'b0;

    run_bist(0, 1'b0, 1'b0, 1'b0, 0, "healthy");

    s1_a[5] = 44'h8;
    run_bist(0, 1'b0, 1'b0, 1'b1, 5, "sa1_a5");
    s1_a[5] = '0;

    run_bist(0, 1'b1, 1'b1, 1'b0, 0, "restart_hold");

    s0_a[9] = 44'h10000000000;
    s0_a[2] = 44'h1;
    run_bist(0, 1'b0, 1'b0, 1'b1, 2, "sa0_a9_a2");
    s0_a[9] = '0; s0_a[2] = '0;

    run_bist(1, 1'b0, 1'b0, 1'b0, 0, "depth48");

    // Abort a running test with reset, then use the functional ports.
    @(negedge clk);
    ba.bist_start = 1'b1;
    @(negedge clk);
    ba.bist_start = 1'b0;
    repeat (49) @(negedge clk);
    chk("mid_busy_before_rst", ba.bist_busy, 1'b1);
    rst_n = 1'b0;
    ba.W0_en = 1'b1; ba.W0_addr = 7'd3; ba.W0_data = 44'h5A; ba.W0_mask = 4'hF;
    #1;
    chk("abort_busy", ba.bist_busy, 1'b0);
    chk("abort_fail", ba.bist_fail, 1'b0);
    chk("abort_csb0", ba.mem_csb0, 1'b0);
    chk("abort_addr0", ba.mem_addr0, 7'd3);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_csb0", ba.mem_csb0, 1'b0);
    @(negedge clk);
    ba.W0_en = 1'b0;
    ba.R0_en = 1'b1; ba.R0_addr = 7'd3;
    rd_q.push_back(44'h5A);
    #1;
    chk("func_csb1", ba.mem_csb1, 1'b0);
    @(negedge clk);
    ba.R0_en = 1'b0;
    chk("func_rd_data", ba.R0_data, rd_q.pop_front());
    chk("post_rst_done", ba.bist_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
